psola_frame_scheduler: RTL and testbench

- Sequences the PSOLA engine once per analysis frame.
- Pairs each filled input frame with the latest pitch period, launches the engine, and supervises completion with a timeout.
- Then streams the result to the output FIFO by generating read addresses.
- Out-of-range or missing periods bypass the engine and replay the raw frame instead.

---
 rtl/psola_pkg.sv | 32 +++
 rtl/psola_drain_addr_gen.sv | 47 ++++
 rtl/psola_frame_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_psola_frame_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psola_pkg.sv
// Shared types and helpers for the PSOLA frame scheduler.
package psola_pkg;

  localparam int unsigned PERIOD_W  = 12;
  localparam int unsigned PERIOD_XW = PERIOD_W + 1;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned LEN_XW    = LEN_W + 1;
  localparam int unsigned DROP_W    = 8;

  localparam logic SRC_PSOLA = 1'b0;
  localparam logic SRC_RAW   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PER,
    LAUNCH,
    RUN,
    DRAIN_PS,
    DRAIN_RAW,
    FINISH
  } sched_state_t;

  // One bit wider than the period so window_size/2 never wraps.
  function automatic logic period_in_range(input logic [PERIOD_W-1:0] period,
                                           input int unsigned         min_period,
                                           input int unsigned         window_size);
    logic [PERIOD_XW-1:0] p_ext;
    p_ext = {1'b0, period};
    return (p_ext >= PERIOD_XW'(min_period)) && (p_ext < PERIOD_XW'(window_size / 2));
  endfunction

endpackage

// File: rtl/psola_drain_addr_gen.sv
// Valid/ready read-address generator shared by the engine and raw drain paths.
module psola_drain_addr_gen
  import psola_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          i_start_c,
  input  logic [AW-1:0] i_len,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic          o_last_c
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_len;
  logic          w_fire;

  assign w_fire   = r_valid & i_ready;
  assign o_last_c = w_fire & (r_addr == (r_len - AW'(1)));
  assign o_valid  = r_valid;
  assign o_addr   = r_addr;

  // Address advances only on an accepted beat; valid never depends on ready.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
    end else if (i_start_c) begin
      r_valid <= 1'b1;
      r_addr  <= '0;
      r_len   <= i_len;
    end else if (w_fire) begin
      if (o_last_c) begin
        r_valid <= 1'b0;
        r_addr  <= '0;
      end else begin
        r_addr <= r_addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/psola_frame_scheduler.sv
// Per-frame sequencer: pairs frames with pitch periods, runs the PSOLA engine
// under a timeout, and streams engine or raw samples to the output FIFO.
module psola_frame_scheduler
  import psola_pkg::*;
#(
  parameter int unsigned WINDOW_SIZE = 2048,
  parameter int unsigned MIN_PERIOD  = 16,
  parameter int unsigned PERIOD_WAIT = 256,
  parameter int unsigned TIMEOUT     = 65536
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         frame_ready_in,
  input  logic                         period_valid_in,
  input  logic [PERIOD_W-1:0]          period_in,
  output logic                         psola_new_signal_out,
  output logic [PERIOD_W-1:0]          psola_period_out,
  output logic                         psola_rst_out,
  input  logic                         psola_done_in,
  input  logic [LEN_W-1:0]             psola_len_in,
  output logic                         rd_src_sel_out,
  output logic [$clog2(WINDOW_SIZE):0] rd_addr_out,
  output logic                         sample_valid_out,
  input  logic                         sample_ready_in,
  output logic                         frame_done_out,
  output logic                         busy_out,
  output logic                         timeout_err_out,
  output logic [DROP_W-1:0]            dropped_frames_out
);

  localparam int unsigned AW      = $clog2(WINDOW_SIZE) + 1;
  localparam int unsigned LEN_MAX = 2 * WINDOW_SIZE - 1;
  localparam int unsigned CNT_W   = ($clog2(TIMEOUT) > $clog2(PERIOD_WAIT)) ?
                                    $clog2(TIMEOUT) : $clog2(PERIOD_WAIT);

  sched_state_t        r_state, w_next;
  logic                r_per_ok;
  logic [PERIOD_W-1:0] r_period;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                r_new, w_new_d;
  logic [PERIOD_W-1:0] r_period_out, w_period_out_d;
  logic                r_rst, w_rst_d;
  logic                r_err, w_err_d;
  logic                r_src, w_src_d;
  logic                r_done, w_done_d;
  logic                r_busy, w_busy_d;
  logic [DROP_W-1:0]   r_drops, w_drops_d;
  logic                w_per_clr;
  logic                w_in_range;
  logic [AW-1:0]       w_len_clamped;
  logic                w_start_c;
  logic [AW-1:0]       w_drain_len;
  logic                w_last_c;

  assign w_in_range    = period_in_range(r_period, MIN_PERIOD, WINDOW_SIZE);
  assign w_len_clamped = ({1'b0, psola_len_in} > LEN_XW'(LEN_MAX)) ? AW'(LEN_MAX)
                                                                   : AW'(psola_len_in);

  // Period capture runs in every state; a consumed period is invalidated.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_per_ok <= 1'b0;
      r_period <= '0;
    end else if (period_valid_in) begin
      r_per_ok <= 1'b1;
      r_period <= period_in;
    end else if (w_per_clr) begin
      r_per_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_new        <= 1'b0;
      r_period_out <= '0;
      r_rst        <= 1'b0;
      r_err        <= 1'b0;
      r_src        <= SRC_PSOLA;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_drops      <= '0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_d;
      r_new        <= w_new_d;
      r_period_out <= w_period_out_d;
      r_rst        <= w_rst_d;
      r_err        <= w_err_d;
      r_src        <= w_src_d;
      r_done       <= w_done_d;
      r_busy       <= w_busy_d;
      r_drops      <= w_drops_d;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_cnt_d        = r_cnt;
    w_new_d        = 1'b0;
    w_period_out_d = r_period_out;
    w_rst_d        = 1'b0;
    w_err_d        = r_err;
    w_per_clr      = 1'b0;
    w_start_c      = 1'b0;
    w_drain_len    = w_len_clamped;

    case (r_state)
      IDLE: begin
        if (frame_ready_in) begin
          if (r_per_ok) begin
            w_per_clr = 1'b1;
            w_next    = w_in_range ? LAUNCH : DRAIN_RAW;
          end else begin
            w_next  = WAIT_PER;
            w_cnt_d = '0;
          end
        end
      end
      WAIT_PER: begin
        // A fresh strobe holds the wait so the captured period is evaluated next cycle.
        if (r_per_ok) begin
          w_per_clr = 1'b1;
          w_next    = w_in_range ? LAUNCH : DRAIN_RAW;
        end else if (frame_ready_in) begin
          w_cnt_d = '0;
        end else if (!period_valid_in) begin
          if (r_cnt == CNT_W'(PERIOD_WAIT - 1)) begin
            w_next = DRAIN_RAW;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
      end
      LAUNCH: begin
        w_new_d        = 1'b1;
        w_period_out_d = r_period;
        w_cnt_d        = '0;
        w_next         = RUN;
      end
      RUN: begin
        if (psola_done_in) begin
          if (w_len_clamped == '0) begin
            w_next = FINISH;
          end else begin
            w_next    = DRAIN_PS;
            w_start_c = 1'b1;
          end
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_rst_d = 1'b1;
          w_err_d = 1'b1;
          w_next  = DRAIN_RAW;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      DRAIN_PS, DRAIN_RAW: begin
        if (w_last_c) begin
          w_next = FINISH;
        end
      end
      FINISH: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    if ((w_next == DRAIN_RAW) && (r_state != DRAIN_RAW)) begin
      w_start_c   = 1'b1;
      w_drain_len = AW'(WINDOW_SIZE);
    end
  end

  // Status outputs track the state being entered so they align with it.
  always_comb begin
    w_src_d   = (w_next == DRAIN_RAW) ? SRC_RAW : SRC_PSOLA;
    w_done_d  = (w_next == FINISH);
    w_busy_d  = (w_next != IDLE);
    w_drops_d = r_drops;
    if (frame_ready_in && (r_state != IDLE) && (r_drops != '1)) begin
      w_drops_d = r_drops + DROP_W'(1);
    end
  end

  psola_drain_addr_gen #(
    .AW(AW)
  ) u_drain (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_start_c(w_start_c),
    .i_len    (w_drain_len),
    .i_ready  (sample_ready_in),
    .o_valid  (sample_valid_out),
    .o_addr   (rd_addr_out),
    .o_last_c (w_last_c)
  );

  assign psola_new_signal_out = r_new;
  assign psola_period_out     = r_period_out;
  assign psola_rst_out        = r_rst;
  assign rd_src_sel_out       = r_src;
  assign frame_done_out       = r_done;
  assign busy_out             = r_busy;
  assign timeout_err_out      = r_err;
  assign dropped_frames_out   = r_drops;

endmodule

// File: tb/tb_psola_frame_scheduler.sv
// Self-checking bench for psola_frame_scheduler: directed and random frames
// checked against a rule-level model of launch/bypass, drain and timeout.
module tb_psola_frame_scheduler;

  localparam int WINDOW_SIZE = 2048;
  localparam int MIN_PERIOD  = 16;
  localparam int PERIOD_WAIT = 256;
  localparam int TIMEOUT     = 65536;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        frame_ready_in;
  logic        period_valid_in;
  logic [11:0] period_in;
  logic        psola_new_signal_out;
  logic [11:0] psola_period_out;
  logic        psola_rst_out;
  logic        psola_done_in;
  logic [11:0] psola_len_in;
  logic        rd_src_sel_out;
  logic [11:0] rd_addr_out;
  logic        sample_valid_out;
  logic        sample_ready_in;
  logic        frame_done_out;
  logic        busy_out;
  logic        timeout_err_out;
  logic [7:0]  dropped_frames_out;

  int n_assert = 0;
  int n_fail   = 0;

  psola_frame_scheduler #(
    .WINDOW_SIZE(WINDOW_SIZE),
    .MIN_PERIOD (MIN_PERIOD),
    .PERIOD_WAIT(PERIOD_WAIT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .frame_ready_in      (frame_ready_in),
    .period_valid_in     (period_valid_in),
    .period_in           (period_in),
    .psola_new_signal_out(psola_new_signal_out),
    .psola_period_out    (psola_period_out),
    .psola_rst_out       (psola_rst_out),
    .psola_done_in       (psola_done_in),
    .psola_len_in        (psola_len_in),
    .rd_src_sel_out      (rd_src_sel_out),
    .rd_addr_out         (rd_addr_out),
    .sample_valid_out    (sample_valid_out),
    .sample_ready_in     (sample_ready_in),
    .frame_done_out      (frame_done_out),
    .busy_out            (busy_out),
    .timeout_err_out     (timeout_err_out),
    .dropped_frames_out  (dropped_frames_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_in_range(input int p);
    return (p >= MIN_PERIOD) && (p < WINDOW_SIZE / 2);
  endfunction

  // Every address 0..len-1 must appear once, in order, holding while stalled.
  task automatic drain_check(input string tag, input int len, input logic src, input bit rnd);
    int exp_addr;
    int guard;
    bit ok;
    exp_addr = 0;
    guard    = 0;
    ok       = 1'b1;
    while (exp_addr < len && guard < 20000) begin
      if (!sample_valid_out || int'(rd_addr_out) != exp_addr || rd_src_sel_out !== src) ok = 1'b0;
      sample_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sample_ready_in) exp_addr++;
      tick();
      guard++;
    end
    sample_ready_in = 1'b0;
    chk({tag, " seq"}, 32'(ok), 32'd1);
    chk({tag, " count"}, 32'(exp_addr), 32'(len));
    chk({tag, " frame_done"}, 32'(frame_done_out), 32'd1);
    chk({tag, " valid_off"}, 32'(sample_valid_out), 32'd0);
    tick();
    chk({tag, " done_pulse"}, 32'(frame_done_out), 32'd0);
    chk({tag, " idle"}, 32'(busy_out), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int p, input int len, input bit rnd);
    int n;
    bit exp_launch;
    exp_launch = model_in_range(p);
    period_valid_in = 1'b1;
    period_in       = 12'(p);
    tick();
    period_valid_in = 1'b0;
    frame_ready_in  = 1'b1;
    tick();
    frame_ready_in  = 1'b0;
    n = 1;
    while (!psola_new_signal_out && n < 8) begin
      tick();
      n++;
    end
    chk({tag, " launch"}, 32'(psola_new_signal_out), 32'(exp_launch));
    if (exp_launch) begin
      chk({tag, " launch_latency"}, 32'(n), 32'd2);
      chk({tag, " period_out"}, 32'(psola_period_out), 32'(p));
      repeat ($urandom_range(1, 5)) tick();
      chk({tag, " no_early_valid"}, 32'(sample_valid_out), 32'd0);
      psola_done_in = 1'b1;
      psola_len_in  = 12'(len);
      tick();
      psola_done_in = 1'b0;
      chk({tag, " period_hold"}, 32'(psola_period_out), 32'(p));
      if (len == 0) begin
        chk({tag, " zero_len_done"}, 32'(frame_done_out), 32'd1);
        chk({tag, " zero_len_valid"}, 32'(sample_valid_out), 32'd0);
        tick();
        chk({tag, " zero_len_idle"}, 32'(busy_out), 32'd0);
      end else begin
        chk({tag, " valid_latency"}, 32'(sample_valid_out), 32'd1);
        drain_check(tag, len, 1'b0, rnd);
      end
    end else begin
      drain_check(tag, WINDOW_SIZE, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    int p;
    rst_n_in        = 1'b0;
    frame_ready_in  = 1'b0;
    period_valid_in = 1'b0;
    period_in       = '0;
    psola_done_in   = 1'b0;
    psola_len_in    = '0;
    sample_ready_in = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst busy", 32'(busy_out), 32'd0);
    chk("rst valid", 32'(sample_valid_out), 32'd0);
    chk("rst new", 32'(psola_new_signal_out), 32'd0);
    chk("rst drops", 32'(dropped_frames_out), 32'd0);
    chk("rst err", 32'(timeout_err_out), 32'd0);
    rst_n_in = 1'b1;
    tick();
    chk("post_rst busy", 32'(busy_out), 32'd0);

    // Period 200, engine length 2100, ready tied high
    run_frame("t1", 200, 2100, 1'b0);

    // No period ever arrives: raw replay after the wait window
    frame_ready_in = 1'b1;
    tick();
    frame_ready_in = 1'b0;
    n   = 0;
    saw = 1'b0;
    while (!sample_valid_out && n < 400) begin
      if (psola_new_signal_out) saw = 1'b1;
      tick();
      n++;
    end
    chk("t2 wait_cycles", 32'(n), 32'(PERIOD_WAIT));
    chk("t2 no_launch", 32'(saw), 32'd0);
    chk("t2 drops", 32'(dropped_frames_out), 32'd0);
    drain_check("t2", WINDOW_SIZE, 1'b1, 1'b0);

    // Range boundaries and out-of-range bypass
    run_frame("t3_1500", 1500, 16, 1'b0);
    run_frame("t3_8", 8, 16, 1'b0);
    run_frame("t3_15", 15, 16, 1'b0);
    run_frame("t3_16", 16, 5, 1'b1);
    run_frame("t3_1023", 1023, 7, 1'b1);
    run_frame("t3_1024", 1024, 16, 1'b0);
    run_frame("t3_len0", 100, 0, 1'b0);

    // Random ready stall pattern over a 300-sample engine drain
    run_frame("t4", 300, 300, 1'b1);

    // Random periods and lengths
    for (int i = 0; i < 3; i++) begin
      p = int'($urandom_range(0, 2047));
      run_frame("t5_rand", p, int'($urandom_range(1, 64)), 1'b1);
    end

    // Engine never finishes: timeout, sticky error, raw replay
    period_valid_in = 1'b1;
    period_in       = 12'd300;
    tick();
    period_valid_in = 1'b0;
    frame_ready_in  = 1'b1;
    tick();
    frame_ready_in  = 1'b0;
    tick();
    chk("t6 launch", 32'(psola_new_signal_out), 32'd1);
    n   = 0;
    saw = 1'b0;
    while (!psola_rst_out && n < 70000) begin
      if (sample_valid_out) saw = 1'b1;
      tick();
      n++;
    end
    chk("t6 timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("t6 no_early_valid", 32'(saw), 32'd0);
    chk("t6 err", 32'(timeout_err_out), 32'd1);
    chk("t6 raw_src", 32'(rd_src_sel_out), 32'd1);
    drain_check("t6", WINDOW_SIZE, 1'b1, 1'b0);
    chk("t6 rst_pulse_off", 32'(psola_rst_out), 32'd0);
    chk("t6 err_sticky", 32'(timeout_err_out), 32'd1);

    // Overrun during RUN, then reset in the middle of an engine drain
    period_valid_in = 1'b1;
    period_in       = 12'd200;
    tick();
    period_valid_in = 1'b0;
    frame_ready_in  = 1'b1;
    tick();
    frame_ready_in  = 1'b0;
    tick();
    chk("t7 launch", 32'(psola_new_signal_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      frame_ready_in = 1'b1;
      tick();
      frame_ready_in = 1'b0;
      tick();
    end
    chk("t7 drops", 32'(dropped_frames_out), 32'd3);
    psola_done_in = 1'b1;
    psola_len_in  = 12'd40;
    tick();
    psola_done_in   = 1'b0;
    sample_ready_in = 1'b1;
    repeat (5) tick();
    sample_ready_in = 1'b0;
    chk("t7 mid_drain_addr", 32'(rd_addr_out), 32'd5);
    rst_n_in = 1'b0;
    #1;
    chk("t7 async valid", 32'(sample_valid_out), 32'd0);
    chk("t7 async addr", 32'(rd_addr_out), 32'd0);
    chk("t7 async busy", 32'(busy_out), 32'd0);
    chk("t7 async drops", 32'(dropped_frames_out), 32'd0);
    chk("t7 async err", 32'(timeout_err_out), 32'd0);
    chk("t7 async period", 32'(psola_period_out), 32'd0);
    tick();
    chk("t7 no_done", 32'(frame_done_out), 32'd0);
    rst_n_in = 1'b1;
    tick();
    chk("t7 idle", 32'(busy_out), 32'd0);
    run_frame("t7_recover", 64, 20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
